// File: rtl/modulator_pkg.sv
// Shared types and constants for the QPSK frame generator.
// Gray map: bit 0 selects the I sign, bit 1 selects the Q sign.
package modulator_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PREAMBLE = 2'd1,
      DATA     = 2'd2,
      WAIT     = 2'd3
   } state_e;

   localparam int SYMS_PER_WORD = 16;

   localparam logic [1:0] SYM_POS_POS = 2'b00;
   localparam logic [1:0] SYM_NEG_POS = 2'b01;
   localparam logic [1:0] SYM_NEG_NEG = 2'b11;
   localparam logic [1:0] SYM_POS_NEG = 2'b10;

endpackage

// File: rtl/modulator_frame_gen_if.sv
// Word input and symbol output handshakes of the frame generator.
// The master side drives words and out_ready; the slave side is the generator.
interface modulator_frame_gen_if;
   logic               in_valid;
   logic [31:0]        in_data;
   logic               in_ready;
   logic               out_ready;
   logic               out_valid;
   logic signed [31:0] mod_i;
   logic signed [31:0] mod_q;
   logic [31:0]        segment_out;
   logic               frame_start;
   logic               frame_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, mod_i, mod_q, segment_out, frame_start, frame_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, mod_i, mod_q, segment_out, frame_start, frame_last
   );
endinterface

// File: rtl/qpsk_symbol_map.sv
// Combinational Gray-coded QPSK mapper: 2-bit symbol to signed +/-AMP I/Q pair.
// Zero latency; no handshake.
module qpsk_symbol_map
   import modulator_pkg::*;
#(
   parameter logic signed [31:0] AMP = 32'sd1024
) (
   input  logic [1:0]         sym_i,
   output logic signed [31:0] i_o,
   output logic signed [31:0] q_o
);

   always_comb begin
      i_o = AMP;
      q_o = AMP;
      case (sym_i)
         SYM_POS_POS: begin i_o = AMP;  q_o = AMP;  end
         SYM_NEG_POS: begin i_o = -AMP; q_o = AMP;  end
         SYM_NEG_NEG: begin i_o = -AMP; q_o = -AMP; end
         SYM_POS_NEG: begin i_o = AMP;  q_o = -AMP; end
         default:     begin i_o = AMP;  q_o = AMP;  end
      endcase
   end

endmodule

// File: rtl/modulator_frame_gen.sv
// Frames 32-bit words into preamble + Gray QPSK symbols; first symbol valid two edges after word accept.
// Symbols advance only on out_valid && out_ready; all outputs hold while out_ready is low.
module modulator_frame_gen
   import modulator_pkg::*;
#(
   parameter logic signed [31:0] AMP          = 32'sd1024,
   parameter int                 PREAMBLE_LEN = 8,
   parameter int                 FRAME_WORDS  = 4
) (
   input logic                  clk,
   input logic                  reset,
   modulator_frame_gen_if.slave bus
);

   localparam int SYM_W = (PREAMBLE_LEN > SYMS_PER_WORD) ? $clog2(PREAMBLE_LEN) : $clog2(SYMS_PER_WORD);
   localparam int WC_W  = $clog2(FRAME_WORDS) + 1;
   localparam logic [SYM_W-1:0] PRE_LAST   = SYM_W'(PREAMBLE_LEN - 1);
   localparam logic [SYM_W-1:0] WORD_LAST  = SYM_W'(SYMS_PER_WORD - 1);
   localparam logic [WC_W-1:0]  FRAME_LAST = WC_W'(FRAME_WORDS - 1);

   state_e            state_q, state_d;
   logic [SYM_W-1:0]  sym_cnt_q, sym_cnt_d;
   logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
   logic [31:0]       shifter_q, shifter_d;
   logic [31:0]       hold_q, hold_d;
   logic              hold_full_q, hold_full_d;

   logic              out_vld;
   logic              sym_adv;
   logic              load;
   logic [1:0]        sym_sel;
   logic signed [31:0] map_i, map_q;

   assign out_vld = (state_q == PREAMBLE) || (state_q == DATA);
   assign sym_adv = out_vld && bus.out_ready;

   always_comb begin
      state_d     = state_q;
      sym_cnt_d   = sym_cnt_q;
      word_cnt_d  = word_cnt_q;
      shifter_d   = shifter_q;
      load        = 1'b0;
      case (state_q)
         IDLE: begin
            if (hold_full_q) begin
               state_d    = PREAMBLE;
               sym_cnt_d  = '0;
               word_cnt_d = '0;
            end
         end
         PREAMBLE: begin
            if (sym_adv) begin
               if (sym_cnt_q == PRE_LAST) begin
                  load      = 1'b1;
                  sym_cnt_d = '0;
                  state_d   = DATA;
               end else begin
                  sym_cnt_d = sym_cnt_q + 1'b1;
               end
            end
         end
         DATA: begin
            if (sym_adv) begin
               shifter_d = shifter_q << 2;
               if (sym_cnt_q == WORD_LAST) begin
                  sym_cnt_d = '0;
                  if (word_cnt_q == FRAME_LAST) begin
                     word_cnt_d = '0;
                     state_d    = hold_full_q ? PREAMBLE : IDLE;
                  end else begin
                     word_cnt_d = word_cnt_q + 1'b1;
                     if (hold_full_q) load = 1'b1;
                     else             state_d = WAIT;
                  end
               end else begin
                  sym_cnt_d = sym_cnt_q + 1'b1;
               end
            end
         end
         WAIT: begin
            // Mid-frame underrun resumes straight into data, no preamble.
            if (hold_full_q) begin
               load      = 1'b1;
               sym_cnt_d = '0;
               state_d   = DATA;
            end
         end
         default: state_d = IDLE;
      endcase
      if (load) shifter_d = hold_q;
   end

   always_comb begin
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      if (load) begin
         hold_full_d = 1'b0;
      end else if (bus.in_valid && !hold_full_q) begin
         hold_d      = bus.in_data;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         sym_cnt_q   <= '0;
         word_cnt_q  <= '0;
         shifter_q   <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sym_cnt_q   <= sym_cnt_d;
         word_cnt_q  <= word_cnt_d;
         shifter_q   <= shifter_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
      end
   end

   // Preamble alternates symbol 00 / 11 on the parity of its index.
   assign sym_sel = (state_q == PREAMBLE) ? {sym_cnt_q[0], sym_cnt_q[0]} : shifter_q[31:30];

   qpsk_symbol_map #(.AMP(AMP)) u_map (
      .sym_i (sym_sel),
      .i_o   (map_i),
      .q_o   (map_q)
   );

   assign bus.in_ready    = !hold_full_q;
   assign bus.out_valid   = out_vld;
   assign bus.mod_i       = out_vld ? map_i : '0;
   assign bus.mod_q       = out_vld ? map_q : '0;
   assign bus.segment_out = (state_q == DATA) ? 32'(word_cnt_q) : '0;
   assign bus.frame_start = (state_q == PREAMBLE) && (sym_cnt_q == '0);
   assign bus.frame_last  = (state_q == DATA) && (sym_cnt_q == WORD_LAST) && (word_cnt_q == FRAME_LAST);

endmodule

// File: tb/tb_modulator_frame_gen.sv
// Directed bench for modulator_frame_gen with PREAMBLE_LEN=4, FRAME_WORDS=2, AMP=1024.
module tb_modulator_frame_gen;

   localparam logic signed [31:0] AMP = 32'sd1024;
   localparam int PL = 4;
   localparam int FW = 2;

   typedef struct packed {
      logic signed [31:0] i;
      logic signed [31:0] q;
      logic [31:0]        seg;
      logic               fs;
      logic               fl;
   } sym_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   modulator_frame_gen_if bus ();

   modulator_frame_gen #(.AMP(AMP), .PREAMBLE_LEN(PL), .FRAME_WORDS(FW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int   checks = 0;
   int   errors = 0;
   sym_t exp_q[$];
   sym_t obs_q[$];
   int   obs_cyc[$];

   function automatic logic signed [31:0] lvl(input logic neg);
      return neg ? -AMP : AMP;
   endfunction

   // Reference stream: preamble then 16 Gray symbols per word, MSB pair first.
   function automatic void build_expected(input logic [31:0] words[$]);
      sym_t s;
      logic [31:0] w;
      logic [1:0] b;
      exp_q.delete();
      for (int f = 0; f < words.size() / FW; f++) begin
         for (int k = 0; k < PL; k++) begin
            s.i = lvl(k % 2 == 1); s.q = s.i; s.seg = '0; s.fs = (k == 0); s.fl = 1'b0;
            exp_q.push_back(s);
         end
         for (int wi = 0; wi < FW; wi++) begin
            w = words[f*FW + wi];
            for (int n = 0; n < 16; n++) begin
               b = w[31:30];
               w = w << 2;
               s.i = lvl(b[0]); s.q = lvl(b[1]); s.seg = 32'(wi);
               s.fs = 1'b0; s.fl = (wi == FW-1) && (n == 15);
               exp_q.push_back(s);
            end
         end
      end
   endfunction

   task automatic do_reset();
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   // Called at a negedge; the word is taken on the next edge where in_ready is high.
   task automatic push_word(input logic [31:0] w);
      int guard = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      while (!bus.in_ready && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 500) begin
         errors++;
         $display("FAIL push_timeout word=%h in_ready stayed 0 for %0d cycles", w, guard);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic collect(input int cycles);
      sym_t s;
      obs_q.delete();
      obs_cyc.delete();
      for (int c = 1; c <= cycles; c++) begin
         @(negedge clk);
         #1;
         if (bus.out_valid && bus.out_ready) begin
            s = '{bus.mod_i, bus.mod_q, bus.segment_out, bus.frame_start, bus.frame_last};
            obs_q.push_back(s);
            obs_cyc.push_back(c);
         end
      end
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
         errors++; $display("FAIL reset_held valid/ready got %b want 01", {bus.out_valid, bus.in_ready});
      end
      reset = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.frame_start, bus.frame_last} !== 4'b0100) begin
         errors++; $display("FAIL idle_flags got %b want 0100", {bus.out_valid, bus.in_ready, bus.frame_start, bus.frame_last});
      end
      checks++;
      if (bus.mod_i !== 32'sd0 || bus.mod_q !== 32'sd0) begin
         errors++; $display("FAIL idle_iq got %0d,%0d want 0,0", bus.mod_i, bus.mod_q);
      end
      checks++;
      if (bus.segment_out !== 32'd0) begin
         errors++; $display("FAIL idle_segment got %0d want 0", bus.segment_out);
      end
   endtask

   task automatic test_single_frame();
      logic [31:0] words[$];
      sym_t o;
      do_reset();
      words = '{32'h1B000000, 32'hFFFFFFFF};
      build_expected(words);
      fork
         begin push_word(words[0]); push_word(words[1]); end
         collect(60);
      join
      checks++;
      if (obs_q.size() !== 36) begin
         errors++; $display("FAIL single_count got %0d want 36", obs_q.size());
      end
      for (int n = 0; n < exp_q.size(); n++) begin
         o = (n < obs_q.size()) ? obs_q[n] : '0;
         checks++;
         if (o !== exp_q[n]) begin
            errors++; $display("FAIL single_sym[%0d] got i=%0d q=%0d seg=%0d fs=%b fl=%b want i=%0d q=%0d seg=%0d fs=%b fl=%b",
               n, o.i, o.q, o.seg, o.fs, o.fl, exp_q[n].i, exp_q[n].q, exp_q[n].seg, exp_q[n].fs, exp_q[n].fl);
         end
      end
      o = (obs_q.size() > 5) ? obs_q[5] : '0;
      checks++;
      if (o.i !== -32'sd1024 || o.q !== 32'sd1024) begin
         errors++; $display("FAIL single_sym5_literal got %0d,%0d want -1024,1024", o.i, o.q);
      end
      checks++;
      if ((obs_cyc.size() > 0 ? obs_cyc[0] : -1) !== 2) begin
         errors++; $display("FAIL single_latency got %0d want 2", obs_cyc.size() > 0 ? obs_cyc[0] : -1);
      end
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL single_back_to_idle valid=%b ready=%b want 0,1", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] words[$];
      sym_t o, snap;
      do_reset();
      words = '{32'h01234567, 32'h89ABCDEF};
      build_expected(words);
      fork
         begin push_word(words[0]); push_word(words[1]); end
         collect(70);
         begin
            repeat (10) @(negedge clk);
            snap = '{bus.mod_i, bus.mod_q, bus.segment_out, bus.frame_start, bus.frame_last};
            bus.out_ready = 1'b0;
            for (int c = 0; c < 5; c++) begin
               @(negedge clk);
               o = '{bus.mod_i, bus.mod_q, bus.segment_out, bus.frame_start, bus.frame_last};
               checks++;
               if (o !== snap || bus.out_valid !== 1'b1) begin
                  errors++; $display("FAIL stall_stable[%0d] got i=%0d q=%0d seg=%0d v=%b want i=%0d q=%0d seg=%0d v=1",
                     c, o.i, o.q, o.seg, bus.out_valid, snap.i, snap.q, snap.seg);
               end
            end
            bus.out_ready = 1'b1;
         end
      join
      checks++;
      if (obs_q.size() !== 36) begin
         errors++; $display("FAIL bp_count got %0d want 36", obs_q.size());
      end
      for (int n = 0; n < exp_q.size(); n++) begin
         o = (n < obs_q.size()) ? obs_q[n] : '0;
         checks++;
         if (o !== exp_q[n]) begin
            errors++; $display("FAIL bp_sym[%0d] got i=%0d q=%0d seg=%0d want i=%0d q=%0d seg=%0d",
               n, o.i, o.q, o.seg, exp_q[n].i, exp_q[n].q, exp_q[n].seg);
         end
      end
      checks++;
      if ((obs_cyc.size() > 8 ? obs_cyc[8] : -1) !== 15) begin
         errors++; $display("FAIL bp_resume_cycle got %0d want 15", obs_cyc.size() > 8 ? obs_cyc[8] : -1);
      end
   endtask

   task automatic test_underrun();
      logic [31:0] words[$];
      sym_t o;
      do_reset();
      words = '{32'hE4E4E4E4, 32'h3C3C0FF0};
      build_expected(words);
      fork
         begin push_word(words[0]); repeat (31) @(negedge clk); push_word(words[1]); end
         collect(80);
         begin
            repeat (27) @(negedge clk);
            #2;
            checks++;
            if ({bus.out_valid, bus.in_ready} !== 2'b01 || bus.mod_i !== 32'sd0) begin
               errors++; $display("FAIL wait_state valid=%b ready=%b i=%0d want 0,1,0", bus.out_valid, bus.in_ready, bus.mod_i);
            end
         end
      join
      checks++;
      if (obs_q.size() !== 36) begin
         errors++; $display("FAIL ur_count got %0d want 36", obs_q.size());
      end
      for (int n = 0; n < exp_q.size(); n++) begin
         o = (n < obs_q.size()) ? obs_q[n] : '0;
         checks++;
         if (o !== exp_q[n]) begin
            errors++; $display("FAIL ur_sym[%0d] got i=%0d q=%0d seg=%0d fs=%b fl=%b want i=%0d q=%0d seg=%0d fs=%b fl=%b",
               n, o.i, o.q, o.seg, o.fs, o.fl, exp_q[n].i, exp_q[n].q, exp_q[n].seg, exp_q[n].fs, exp_q[n].fl);
         end
      end
      checks++;
      if ((obs_cyc.size() > 20 ? obs_cyc[19] : -1) !== 21 || (obs_cyc.size() > 20 ? obs_cyc[20] : -1) !== 34) begin
         errors++; $display("FAIL ur_gap got %0d,%0d want 21,34",
            obs_cyc.size() > 20 ? obs_cyc[19] : -1, obs_cyc.size() > 20 ? obs_cyc[20] : -1);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] words[$];
      sym_t o;
      int fs_cnt;
      do_reset();
      words = '{32'hDEADBEEF, 32'h00000000, 32'h5A5AA5A5, 32'hC3C33C3C};
      build_expected(words);
      fork
         begin foreach (words[k]) push_word(words[k]); end
         collect(100);
      join
      checks++;
      if (obs_q.size() !== 72) begin
         errors++; $display("FAIL b2b_count got %0d want 72", obs_q.size());
      end
      checks++;
      if ((obs_q.size() == 72 ? obs_cyc[71] - obs_cyc[0] : -1) !== 71) begin
         errors++; $display("FAIL b2b_contiguous span got %0d want 71", obs_q.size() == 72 ? obs_cyc[71] - obs_cyc[0] : -1);
      end
      fs_cnt = 0;
      foreach (obs_q[k]) if (obs_q[k].fs) fs_cnt++;
      checks++;
      if (fs_cnt !== 2) begin
         errors++; $display("FAIL b2b_frame_starts got %0d want 2", fs_cnt);
      end
      for (int n = 0; n < exp_q.size(); n++) begin
         o = (n < obs_q.size()) ? obs_q[n] : '0;
         checks++;
         if (o !== exp_q[n]) begin
            errors++; $display("FAIL b2b_sym[%0d] got i=%0d q=%0d seg=%0d fs=%b fl=%b want i=%0d q=%0d seg=%0d fs=%b fl=%b",
               n, o.i, o.q, o.seg, o.fs, o.fl, exp_q[n].i, exp_q[n].q, exp_q[n].seg, exp_q[n].fs, exp_q[n].fl);
         end
      end
   endtask

   task automatic test_async_reset();
      int g;
      do_reset();
      push_word(32'hFFFF0000);
      push_word(32'h12345678);
      repeat (5) @(negedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
         errors++; $display("FAIL pre_reset_active valid=%b ready=%b want 1,0", bus.out_valid, bus.in_ready);
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.frame_start, bus.frame_last} !== 4'b0100 || bus.mod_i !== 32'sd0 || bus.segment_out !== 32'd0) begin
         errors++; $display("FAIL async_reset flags=%b i=%0d seg=%0d want 0100,0,0",
            {bus.out_valid, bus.in_ready, bus.frame_start, bus.frame_last}, bus.mod_i, bus.segment_out);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL post_reset_quiet valid=%b want 0", bus.out_valid);
      end
      @(negedge clk);
      push_word(32'hC0000000);
      g = 0;
      while (!bus.out_valid && g < 20) begin
         @(negedge clk);
         #1;
         g++;
      end
      checks++;
      if (g !== 1) begin
         errors++; $display("FAIL restart_latency got %0d want 1", g);
      end
      checks++;
      if (bus.frame_start !== 1'b1 || bus.mod_i !== 32'sd1024 || bus.mod_q !== 32'sd1024 || bus.segment_out !== 32'd0) begin
         errors++; $display("FAIL restart_preamble fs=%b i=%0d q=%0d seg=%0d want 1,1024,1024,0",
            bus.frame_start, bus.mod_i, bus.mod_q, bus.segment_out);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_backpressure();
      test_underrun();
      test_back_to_back();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not complete within 200000 time units");
      $fatal(1);
   end

endmodule
